// File: rtl/bbox_pixel_scanner_if.sv
// ----------------------------------------------------------------------------
// bbox_pixel_scanner_if
// Purpose : groups the bounding-box input handshake and the pixel output
//           handshake of bbox_pixel_scanner into one bundle.
// Signals :
//   bbox_valid / bbox_ready      box handshake (upstream -> scanner)
//   XMIN, XMAX, YMIN, YMAX       box corners, unsigned fixed point
//   px_valid / px_ready          pixel handshake (scanner -> downstream)
//   px_x, px_y, px_last          pixel coordinate and end-of-box flag
// Modports:
//   slave  - the scanner side (consumes boxes, produces pixels)
//   master - the environment side (produces boxes, consumes pixels)
// ----------------------------------------------------------------------------
interface bbox_pixel_scanner_if #(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned PIX_W   = 10
);
    logic               bbox_valid;
    logic               bbox_ready;
    logic [COORD_W-1:0] XMIN;
    logic [COORD_W-1:0] XMAX;
    logic [COORD_W-1:0] YMIN;
    logic [COORD_W-1:0] YMAX;
    logic               px_valid;
    logic               px_ready;
    logic [PIX_W-1:0]   px_x;
    logic [PIX_W-1:0]   px_y;
    logic               px_last;

    modport slave (
        input  bbox_valid, XMIN, XMAX, YMIN, YMAX, px_ready,
        output bbox_ready, px_valid, px_x, px_y, px_last
    );

    modport master (
        output bbox_valid, XMIN, XMAX, YMIN, YMAX, px_ready,
        input  bbox_ready, px_valid, px_x, px_y, px_last
    );
endinterface

// File: rtl/bbox_pixel_scanner.sv
// ----------------------------------------------------------------------------
// bbox_pixel_scanner
// Purpose : accepts one triangle bounding box, clips it to the screen and
//           emits every integer pixel inside it, one per px handshake.
// Ports   :
//   CLK    - sole clock, rising edge
//   RST_N  - asynchronous active-low reset
//   bus    - bbox_pixel_scanner_if.slave (box in, pixel out)
//   busy   - a box is being scanned
//   done   - one-cycle pulse once a box is fully consumed
// Options :
//   BBOX_SERPENTINE_EN - when defined, odd rows (relative to the box top)
//                        are walked right-to-left; otherwise all rows are
//                        walked left-to-right.
// ----------------------------------------------------------------------------
module bbox_pixel_scanner #(
    parameter int unsigned COORD_W  = 16,
    parameter int unsigned FRAC_W   = 6,
    parameter int unsigned PIX_W    = 10,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    bbox_pixel_scanner_if.slave   bus,
    output logic                  busy,
    output logic                  done
);

    // One extra bit so compares against SCREEN_W-1 never wrap.
    localparam int unsigned CW = PIX_W + 1;
    localparam logic [CW-1:0] XLIM = CW'(SCREEN_W - 1);
    localparam logic [CW-1:0] YLIM = CW'(SCREEN_H - 1);

    typedef enum logic [1:0] {StIdle, StScan, StFinish} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_xs, r_xe, r_ys, r_ye;
    logic [CW-1:0]  w_xs_nxt, w_xe_nxt, w_ys_nxt, w_ye_nxt;
    logic [CW-1:0]  r_x, r_y, w_x_nxt, w_y_nxt;
`ifdef BBOX_SERPENTINE_EN
    logic           r_dir, w_dir_nxt;   // 1: current row runs right-to-left
`endif

    // Integer parts of the incoming box, truncated to PIX_W bits.
    logic [COORD_W-FRAC_W-1:0] w_xmin_int, w_xmax_int, w_ymin_int, w_ymax_int;
    logic [CW-1:0]             w_xs, w_xe_raw, w_xe, w_ys, w_ye_raw, w_ye;
    logic                      w_empty;
    logic [CW-1:0]             w_row_end;
    logic                      w_at_row_end, w_at_last;

    assign w_xmin_int = bus.XMIN[COORD_W-1:FRAC_W];
    assign w_xmax_int = bus.XMAX[COORD_W-1:FRAC_W];
    assign w_ymin_int = bus.YMIN[COORD_W-1:FRAC_W];
    assign w_ymax_int = bus.YMAX[COORD_W-1:FRAC_W];

    assign w_xs     = {1'b0, w_xmin_int[PIX_W-1:0]};
    assign w_ys     = {1'b0, w_ymin_int[PIX_W-1:0]};
    assign w_xe_raw = {1'b0, w_xmax_int[PIX_W-1:0]};
    assign w_ye_raw = {1'b0, w_ymax_int[PIX_W-1:0]};
    assign w_xe     = (w_xe_raw > XLIM) ? XLIM : w_xe_raw;
    assign w_ye     = (w_ye_raw > YLIM) ? YLIM : w_ye_raw;
    assign w_empty  = (w_xs > w_xe) || (w_ys > w_ye);

`ifdef BBOX_SERPENTINE_EN
    assign w_row_end = r_dir ? r_xs : r_xe;
`else
    assign w_row_end = r_xe;
`endif
    assign w_at_row_end = (r_x == w_row_end);
    assign w_at_last    = w_at_row_end && (r_y == r_ye);

    // Outputs are pure functions of registered state, so they hold
    // automatically while the downstream stalls.
    assign bus.bbox_ready = (r_state == StIdle);
    assign bus.px_valid   = (r_state == StScan);
    assign bus.px_x       = r_x[PIX_W-1:0];
    assign bus.px_y       = r_y[PIX_W-1:0];
    assign bus.px_last    = (r_state == StScan) && w_at_last;
    assign busy           = (r_state == StScan);
    assign done           = (r_state == StFinish);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_xs <= '0;
            r_xe <= '0;
            r_ys <= '0;
            r_ye <= '0;
            r_x  <= '0;
            r_y  <= '0;
`ifdef BBOX_SERPENTINE_EN
            r_dir <= 1'b0;
`endif
        end else begin
            r_xs <= w_xs_nxt;
            r_xe <= w_xe_nxt;
            r_ys <= w_ys_nxt;
            r_ye <= w_ye_nxt;
            r_x  <= w_x_nxt;
            r_y  <= w_y_nxt;
`ifdef BBOX_SERPENTINE_EN
            r_dir <= w_dir_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xs_nxt    = r_xs;
        w_xe_nxt    = r_xe;
        w_ys_nxt    = r_ys;
        w_ye_nxt    = r_ye;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
`ifdef BBOX_SERPENTINE_EN
        w_dir_nxt   = r_dir;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.bbox_valid) begin
                    w_xs_nxt    = w_xs;
                    w_xe_nxt    = w_xe;
                    w_ys_nxt    = w_ys;
                    w_ye_nxt    = w_ye;
                    w_x_nxt     = w_xs;
                    w_y_nxt     = w_ys;
`ifdef BBOX_SERPENTINE_EN
                    w_dir_nxt   = 1'b0;
`endif
                    w_state_nxt = w_empty ? StFinish : StScan;
                end
            end
            StScan: begin
                if (bus.px_ready) begin
                    if (!w_at_row_end) begin
`ifdef BBOX_SERPENTINE_EN
                        w_x_nxt = r_dir ? (r_x - CW'(1)) : (r_x + CW'(1));
`else
                        w_x_nxt = r_x + CW'(1);
`endif
                    end else if (r_y != r_ye) begin
                        w_y_nxt = r_y + CW'(1);
`ifdef BBOX_SERPENTINE_EN
                        // x stays at the row end; the next row runs backwards.
                        w_dir_nxt = ~r_dir;
`else
                        w_x_nxt = r_xs;
`endif
                    end else begin
                        w_state_nxt = StFinish;
                    end
                end
            end
            StFinish: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule
